// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the hh:mm:ss counter chain: key debounce, RUN/SET FSM,
// increment/clear strobes, timeout and blink mask. Optional auto-repeat under CLOCK_SET_REPEAT_EN.
module clock_set_ctrl #(
  parameter logic [15:0] DEB_CYCLES    = 16'd1000,
  parameter logic [7:0]  BLINK_TICKS   = 8'd1,
  parameter logic [7:0]  TIMEOUT_TICKS = 8'd30
`ifdef CLOCK_SET_REPEAT_EN
  , parameter logic [7:0] REPEAT_DELAY = 8'd2
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_add,
  input  logic       tick,
  output logic       clock_run,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic [2:0] blink_mask
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  // Key path, index 0 = mode key, index 1 = add key.
  logic [1:0]  sync1, sync2, deb, armed, key_press;
  logic [1:0]  vld;
  logic [15:0] deb_cnt [2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      armed <= '0;
      vld   <= '0;
      // NOTE: the counter array is a pair of flops, not a RAM, so resetting every entry is cheap and required.
      for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage pipeline.
      sync1 <= {key_add, key_mode};
      sync2 <= sync1;
      vld   <= {vld[0], 1'b1};
      for (int k = 0; k < 2; k++) begin
        if (deb_cnt[k] == DEB_CYCLES) begin
          deb[k]     <= sync2[k];
          deb_cnt[k] <= '0;
        end else if (sync2[k] != deb[k]) begin
          deb_cnt[k] <= deb_cnt[k] + 16'd1;
        end else begin
          deb_cnt[k] <= '0;
        end
        // A key held through reset stays unarmed until it has been seen released.
        if (vld[1] && !sync2[k]) armed[k] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      key_press[k] = armed[k] && (deb_cnt[k] == DEB_CYCLES) && sync2[k] && !deb[k];
  end

  // Control FSM and its registered outputs.
  state_t     state, state_nx;
  logic [7:0] to_cnt, to_cnt_nx, blink_cnt, blink_cnt_nx;
  logic       blink_phase, blink_phase_nx;
  logic       inc_hour_nx, inc_min_nx, clr_sec_nx;
  logic [2:0] mask_nx;
  logic       add_fire, kick;
`ifdef CLOCK_SET_REPEAT_EN
  logic [7:0] rep_cnt, rep_cnt_nx;
  logic       rep_fire;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nx       = state;
    to_cnt_nx      = to_cnt;
    blink_cnt_nx   = blink_cnt;
    blink_phase_nx = blink_phase;
    inc_hour_nx    = 1'b0;
    inc_min_nx     = 1'b0;
    clr_sec_nx     = 1'b0;
    add_fire       = key_press[1];
    kick           = key_press[0] | key_press[1];
`ifdef CLOCK_SET_REPEAT_EN
    rep_cnt_nx = rep_cnt;
    rep_fire   = 1'b0;
    if (!deb[1] || key_press[1] || !(state == SET_HOUR || state == SET_MIN)) begin
      rep_cnt_nx = '0;
    end else if (tick) begin
      if (rep_cnt >= REPEAT_DELAY) rep_fire = 1'b1;
      else rep_cnt_nx = rep_cnt + 8'd1;
    end
    add_fire = key_press[1] | rep_fire;
    kick     = kick | rep_fire;
`endif

    // Timeout beats any key activity on the same cycle; a mode press beats an add press.
    if (state != RUN && to_cnt == TIMEOUT_TICKS) begin
      state_nx = RUN;
    end else if (key_press[0]) begin
      state_nx = state_t'(state + 2'd1);
    end else if (add_fire) begin
      case (state)
        SET_HOUR: inc_hour_nx = 1'b1;
        SET_MIN:  inc_min_nx  = 1'b1;
        SET_SEC:  clr_sec_nx  = 1'b1;
        default:  ;
      endcase
    end

    if (state_nx != state || state == RUN || kick) to_cnt_nx = '0;
    else if (tick) to_cnt_nx = to_cnt + 8'd1;

    if (state_nx != state && state_nx != RUN) begin
      blink_phase_nx = 1'b1;
      blink_cnt_nx   = '0;
    end else if (tick) begin
      if (blink_cnt >= BLINK_TICKS - 8'd1) begin
        blink_phase_nx = ~blink_phase;
        blink_cnt_nx   = '0;
      end else begin
        blink_cnt_nx = blink_cnt + 8'd1;
      end
    end

`ifdef CLOCK_SET_REPEAT_EN
    if (state_nx != state) rep_cnt_nx = '0;
`endif

    case (state_nx)
      SET_HOUR: mask_nx = {blink_phase_nx, 2'b11};
      SET_MIN:  mask_nx = {1'b1, blink_phase_nx, 1'b1};
      SET_SEC:  mask_nx = {2'b11, blink_phase_nx};
      default:  mask_nx = 3'b111;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      to_cnt      <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      clock_run   <= 1'b1;
      inc_hour    <= 1'b0;
      inc_min     <= 1'b0;
      clr_sec     <= 1'b0;
      blink_mask  <= 3'b111;
`ifdef CLOCK_SET_REPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      state       <= state_nx;
      to_cnt      <= to_cnt_nx;
      blink_cnt   <= blink_cnt_nx;
      blink_phase <= blink_phase_nx;
      clock_run   <= (state_nx == RUN);
      inc_hour    <= inc_hour_nx;
      inc_min     <= inc_min_nx;
      clr_sec     <= clr_sec_nx;
      blink_mask  <= mask_nx;
`ifdef CLOCK_SET_REPEAT_EN
      rep_cnt     <= rep_cnt_nx;
`endif
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with DEB_CYCLES=4, BLINK_TICKS=1, TIMEOUT_TICKS=3.
// Strobes are logged by a monitor and matched against a scoreboard of expected strobes.
module tb_clock_set_ctrl;

  logic       clock = 1'b0;
  logic       reset, key_mode, key_add, tick;
  logic       clock_run, inc_hour, inc_min, clr_sec;
  logic [1:0] mode;
  logic [2:0] blink_mask;
  logic [2:0] strobe_code;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q [$];
  logic [2:0] obs_log [64];
  int         obs_count     = 0;
  int         inc_min_count = 0;
  int         rd_ptr        = 0;

  typedef struct {
    logic       km;
    logic       ka;
    logic [1:0] exp_mode;
    logic [2:0] exp_strobe;
    logic [2:0] exp_mask;
    string      name;
  } vec_t;

  vec_t vecs [12];

  clock_set_ctrl #(
    .DEB_CYCLES   (16'd4),
    .BLINK_TICKS  (8'd1),
    .TIMEOUT_TICKS(8'd3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_mode  (key_mode),
    .key_add   (key_add),
    .tick      (tick),
    .clock_run (clock_run),
    .inc_hour  (inc_hour),
    .inc_min   (inc_min),
    .clr_sec   (clr_sec),
    .mode      (mode),
    .blink_mask(blink_mask)
  );

  always #5 clock = ~clock;

  assign strobe_code = {inc_hour, inc_min, clr_sec};

  // Every high strobe sample is one logged event; a strobe wider than a cycle logs twice.
  always @(negedge clock) begin
    if (strobe_code != 3'b000) begin
      if (obs_count < 64) obs_log[obs_count] <= strobe_code;
      obs_count <= obs_count + 1;
      if (inc_min) inc_min_count <= inc_min_count + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    while (rd_ptr < obs_count) begin
      if (rd_ptr >= 64) begin
        check("strobe_log_overflow", rd_ptr, 63);
        rd_ptr = obs_count;
      end else if (exp_q.size() == 0) begin
        check("unexpected_strobe", int'(obs_log[rd_ptr]), 0);
        rd_ptr++;
      end else begin
        check("strobe_order", int'(obs_log[rd_ptr]), int'(exp_q.pop_front()));
        rd_ptr++;
      end
    end
  endtask

  task automatic check_outputs(input string name, input logic [1:0] m, input logic [2:0] mask);
    check({name, "_mode"}, int'(mode), int'(m));
    check({name, "_run"}, int'(clock_run), int'(m == 2'd0));
    check({name, "_mask"}, int'(blink_mask), int'(mask));
  endtask

  // Raise keys, expect nothing through edge 6, the effect on edge 7, and a one-cycle strobe.
  task automatic press(input logic km, input logic ka, input logic [1:0] old_mode,
                       input logic [1:0] exp_mode, input logic [2:0] exp_strobe,
                       input logic [2:0] exp_mask, input string name);
    key_mode = km;
    key_add  = ka;
    if (exp_strobe != 3'b000) exp_q.push_back(exp_strobe);
    repeat (6) step();
    check({name, "_early_mode"}, int'(mode), int'(old_mode));
    step();
    check_outputs(name, exp_mode, exp_mask);
    check({name, "_strobe"}, int'(strobe_code), int'(exp_strobe));
    step();
    check({name, "_strobe_width"}, int'(strobe_code), 0);
    key_mode = 1'b0;
    key_add  = 1'b0;
    repeat (10) step();
    drain();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    logic [1:0] cur_mode;
    int         min_base;
    int         exp_reps;

    vecs[0]  = '{1'b0, 1'b1, 2'd0, 3'b000, 3'b111, "add_in_run"};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 3'b000, 3'b111, "run_to_hour"};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 3'b100, 3'b111, "inc_hour"};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 3'b000, 3'b111, "hour_to_min"};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 3'b010, 3'b111, "inc_min"};
    vecs[5]  = '{1'b1, 1'b0, 2'd3, 3'b000, 3'b111, "min_to_sec"};
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 3'b001, 3'b111, "clr_sec"};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 3'b000, 3'b111, "sec_to_run"};
    vecs[8]  = '{1'b1, 1'b0, 2'd1, 3'b000, 3'b111, "run_to_hour2"};
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 3'b000, 3'b111, "both_in_hour"};
    vecs[10] = '{1'b1, 1'b0, 2'd3, 3'b000, 3'b111, "min_to_sec2"};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 3'b000, 3'b111, "both_in_sec"};

    reset    = 1'b1;
    key_mode = 1'b0;
    key_add  = 1'b0;
    tick     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_outputs("reset", 2'd0, 3'b111);
    check("reset_strobes", int'(strobe_code), 0);
    reset = 1'b0;
    repeat (5) step();

    // Pulse of 3 cycles is shorter than the debounce window.
    key_mode = 1'b1;
    repeat (3) step();
    key_mode = 1'b0;
    repeat (12) step();
    drain();
    check_outputs("short_pulse", 2'd0, 3'b111);

    cur_mode = 2'd0;
    for (int i = 0; i < 12; i++) begin
      press(vecs[i].km, vecs[i].ka, cur_mode, vecs[i].exp_mode, vecs[i].exp_strobe,
            vecs[i].exp_mask, vecs[i].name);
      cur_mode = vecs[i].exp_mode;
    end

    // Timeout and blink in SET_HOUR: hour bit toggles per tick, third tick times out.
    press(1'b1, 1'b0, 2'd0, 2'd1, 3'b000, 3'b111, "to_hour_for_timeout");
    pulse_tick();
    check_outputs("blink_tick1", 2'd1, 3'b011);
    step();
    pulse_tick();
    check_outputs("blink_tick2", 2'd1, 3'b111);
    step();
    pulse_tick();
    check_outputs("blink_tick3", 2'd1, 3'b011);
    step();
    check_outputs("timeout", 2'd0, 3'b111);
    check("timeout_strobes", int'(strobe_code), 0);
    repeat (3) step();
    drain();

    // Hold add for 6 ticks in SET_MIN.
    press(1'b1, 1'b0, 2'd0, 2'd1, 3'b000, 3'b111, "to_hour_for_repeat");
    press(1'b1, 1'b0, 2'd1, 2'd2, 3'b000, 3'b111, "to_min_for_repeat");
    min_base = inc_min_count;
    key_add  = 1'b1;
    exp_q.push_back(3'b010);
`ifdef CLOCK_SET_REPEAT_EN
    exp_reps = 5;
    repeat (4) exp_q.push_back(3'b010);
`else
    exp_reps = 1;
`endif
    repeat (6) step();
    check("hold_add_early", int'(strobe_code), 0);
    step();
    check("hold_add_first", int'(strobe_code), 3'b010);
    for (int t = 0; t < 6; t++) begin
      repeat (2) step();
      pulse_tick();
    end
    key_add = 1'b0;
    repeat (10) step();
    drain();
    check("hold_add_inc_min_count", inc_min_count - min_base, exp_reps);
    for (int t = 0; t < 4; t++) begin
      pulse_tick();
      step();
    end
    step();
    check_outputs("after_hold", 2'd0, 3'b111);

    // Reset mid-debounce, then the held key must be released and re-pressed.
    press(1'b1, 1'b0, 2'd0, 2'd1, 3'b000, 3'b111, "to_hour_for_reset");
    key_mode = 1'b1;
    repeat (3) step();
    #3;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", 2'd0, 3'b111);
    check("async_reset_strobes", int'(strobe_code), 0);
    step();
    reset = 1'b0;
    repeat (20) step();
    check_outputs("held_through_reset", 2'd0, 3'b111);
    key_mode = 1'b0;
    repeat (10) step();
    press(1'b1, 1'b0, 2'd0, 2'd1, 3'b000, 3'b111, "repress_after_reset");

    drain();
    check("missing_strobes", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode/set controller for the hh:mm:ss clock counter chain.
- Debounces the two user keys, key_mode and key_add.
- Runs the RUN / SET_HOUR / SET_MIN / SET_SEC state machine.
- Gates the clock run enable and issues single-cycle increment and clear strobes to the hour, minute and second counters.
- Generates the per-field blink mask used by the 7-segment display path.

Parameters:
- DEB_CYCLES, 16'd1000: consecutive stable cycles on a synchronised key before its debounced level changes; legal range 1..65535.
- BLINK_TICKS, 8'd1: number of tick pulses per blink-phase toggle.
- TIMEOUT_TICKS, 8'd30: tick pulses with no debounced press in a SET state before automatic return to RUN.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_mode  in  1  raw mode key, active-high (pressed = 1), asynchronous to clock.
- key_add  in  1  raw add key, active-high, asynchronous to clock.
- tick  in  1  one-cycle seconds-base pulse from the clock divider; must keep pulsing while clock_run = 0.
- clock_run  out  1  run enable for the counter chain.
- inc_hour  out  1  one-cycle hour increment strobe.
- inc_min  out  1  one-cycle minute increment strobe.
- clr_sec  out  1  one-cycle seconds-clear strobe.
- mode  out  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- blink_mask  out  3  per-field display enable {hour, min, sec}; 1 = field visible.

Behaviour:
- Reset (asynchronous, active-high), all registered:
  - mode = 0, clock_run = 1, all strobes = 0, blink_mask = 3'b111.
  - Synchronisers and debounced levels = 0, debounce counters = 0, blink_phase = 1, timeout counter = 0.
- Key path, per key:
  - 2-FF synchroniser.
  - 16-bit counter increments while the synchronised level differs from the debounced level, and clears to 0 when they match.
  - When the count reaches DEB_CYCLES: debounced level takes the synchronised value and the counter clears.
  - Press event = debounced 0->1 transition. Releases generate nothing.
- Latency: a raw key rising and held stable produces its output strobe / state change on clock edge DEB_CYCLES+3 counted from the first edge that samples it high. Pulses shorter than DEB_CYCLES cycles are ignored.
- FSM transitions on a mode press: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
- clock_run = 1 only in RUN. It drops on the same edge that mode leaves 0.
- Add press, by state:
  - RUN: ignored.
  - SET_HOUR: inc_hour = 1 for one cycle.
  - SET_MIN: inc_min = 1 for one cycle.
  - SET_SEC: clr_sec = 1 for one cycle.
  - Wrap-around (23->0, 59->0) belongs to the counters, not to this block.
- Simultaneous mode and add press on the same cycle: mode wins, the add press is discarded, no strobe.
- Timeout:
  - In SET states, count tick pulses; the counter clears on any debounced press of either key and on every state change.
  - On reaching TIMEOUT_TICKS: mode = 0 and clock_run = 1 on the next edge. No strobe is emitted on that edge.
- Blink:
  - blink_phase toggles after every BLINK_TICKS tick pulses, in all states.
  - RUN: blink_mask = 3'b111.
  - SET states: only the edited field's bit follows blink_phase; the other two bits stay 1.
  - Entering any SET state forces blink_phase = 1 and clears the blink counter.
- Strobes are mutually exclusive and never exceed one cycle.
- Reset asserted mid-press or mid-debounce: everything returns to reset values. A key still held at reset release must be released and re-pressed to generate an event.

Optional Feature:
- Macro: CLOCK_SET_REPEAT_EN.
- Defined:
  - In SET_HOUR/SET_MIN, holding key_add at debounced level 1 for 2 tick pulses after the press starts auto-repeat.
  - Auto-repeat issues one additional inc_hour/inc_min per tick pulse until release.
  - Auto-repeat also clears the timeout counter.
  - SET_SEC never repeats.
  - Parameter REPEAT_DELAY, 8'd2, is added.
- Not defined: exactly one strobe per press; no repeat logic synthesised.

Test Plan:
All scenarios use DEB_CYCLES=4 and BLINK_TICKS=1.
1. Reset asserted -> mode=0, clock_run=1, blink_mask=3'b111, all strobes 0.
2. key_mode high for 3 cycles, then low -> no state change. key_mode high and held -> mode=1 and clock_run=0 exactly on edge 7.
3. In SET_MIN, key_add press -> inc_min high for exactly 1 cycle, edge 7 after the rise. In SET_SEC -> clr_sec for 1 cycle, no inc strobes.
4. In SET_HOUR, both keys rise on the same cycle -> mode=2, no inc_hour.
5. In SET_HOUR with TIMEOUT_TICKS=3 and no key presses -> after the 3rd tick, mode=0 and clock_run=1. blink_mask[2] toggles on each tick while in SET_HOUR.
6. CLOCK_SET_REPEAT_EN defined, key_add held 6 ticks in SET_MIN -> 5 inc_min pulses (1 press + 4 repeats). Undefined -> 1 pulse.
